fsm_line_scheduler: RTL and testbench

Frame scheduler that shares the two-line sequence FSM between two requesters. It owns the FSM's synchronous reset and drives its `line1`/`line2` inputs every cycle. It hands the FSM out in fixed 4-beat frames, one per pass around the FSM's 4-stage state ring, using round-robin arbitration. It also counts, per requester, the frames that drove the FSM into overflow.

---
 rtl/fsm_line_scheduler_if.sv | 20 ++
 rtl/fsm_line_scheduler.sv | 75 +++++++
 tb/tb_fsm_line_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fsm_line_scheduler_if.sv
// fsm_line_scheduler_if: requester handshake and frame status bundle
interface fsm_line_scheduler_if;
  logic       req0_valid;
  logic       req1_valid;
  logic [1:0] req0_line;
  logic [1:0] req1_line;
  logic       req0_ready;
  logic       req1_ready;
  logic [1:0] grant;
  logic       frame_done;
  logic       bubble;
  modport master (
    output req0_valid, req1_valid, req0_line, req1_line,
    input  req0_ready, req1_ready, grant, frame_done, bubble
  );
  modport slave (
    input  req0_valid, req1_valid, req0_line, req1_line,
    output req0_ready, req1_ready, grant, frame_done, bubble
  );
endinterface

// File: rtl/fsm_line_scheduler.sv
// fsm_line_scheduler: round-robin 4-beat frame sharing of the line FSM; SCHED_OVF_CNT_EN builds overflow counters
module fsm_line_scheduler #(
  parameter int CNT_W     = 8,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  fsm_line_scheduler_if.slave req,
  output logic               fsm_reset,
  output logic               line1,
  output logic               line2,
  input  logic               overflw,
  input  logic               ovf_clear,
  output logic [CNT_W-1:0]   ovf_count0,
  output logic [CNT_W-1:0]   ovf_count1
);
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  logic [0:0] state;
  logic [1:0] beat;
  logic [1:0] grant;
  logic       rr;
  logic       arb;
  logic       tie;
  logic [1:0] next_grant;
  logic       sel_valid;
  logic [1:0] sel_line;
  assign arb       = (state == ST_INIT) || (beat == 2'd3);
  assign tie       = req.req0_valid && req.req1_valid;
  assign fsm_reset = (state == ST_INIT);
  // tie goes to the pointer's requester; otherwise the lone valid one (or nobody)
  always_comb next_grant = tie ? (rr ? 2'b10 : 2'b01) : {req.req1_valid, req.req0_valid};
  // INIT exit, beat ring aligned to the FSM, and frame-boundary arbitration
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= ST_INIT;
      beat  <= 2'd0;
      grant <= 2'b00;
      rr    <= PRIO_INIT;
    end else begin
      state <= ST_RUN;
      beat  <= (state == ST_RUN) ? beat + 2'd1 : 2'd0;
      if (arb) grant <= next_grant;
      if (arb && tie) rr <= ~rr;
    end
  assign sel_valid      = grant[0] ? req.req0_valid : (grant[1] ? req.req1_valid : 1'b0);
  assign sel_line       = grant[0] ? req.req0_line : req.req1_line;
  assign {line1, line2} = sel_valid ? sel_line : 2'b00;
  assign req.bubble     = (|grant) && !sel_valid;
  assign req.grant      = grant;
  assign req.req0_ready = grant[0];
  assign req.req1_ready = grant[1];
  assign req.frame_done = (state == ST_RUN) && (beat == 2'd3);
`ifdef SCHED_OVF_CNT_EN
  logic [1:0] prev_grant;
  logic       hit;
  assign hit = (state == ST_RUN) && (beat == 2'd1) && overflw;
  // overflow on beat 1 belongs to the previous frame's owner; clear beats increment
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      prev_grant <= 2'b00;
      ovf_count0 <= '0;
      ovf_count1 <= '0;
    end else begin
      if (arb) prev_grant <= grant;
      ovf_count0 <= ovf_clear ? '0 : (hit && prev_grant[0] && !(&ovf_count0)) ? ovf_count0 + 1'b1 : ovf_count0;
      ovf_count1 <= ovf_clear ? '0 : (hit && prev_grant[1] && !(&ovf_count1)) ? ovf_count1 + 1'b1 : ovf_count1;
    end
`else
  logic unused_ovf;
  assign unused_ovf = overflw ^ ovf_clear;
  assign ovf_count0 = '0;
  assign ovf_count1 = '0;
`endif
endmodule

// File: tb/tb_fsm_line_scheduler.sv
// tb_fsm_line_scheduler: directed checks of framing, round-robin, bubbles, overflow counting and reset
module tb_fsm_line_scheduler;
`ifdef SCHED_OVF_CNT_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       fsm_reset, line1, line2;
  logic       overflw = 1'b0;
  logic       ovf_clear = 1'b0;
  logic [7:0] ovf_count0, ovf_count1;
  int         n_chk = 0;
  int         n_pass = 0;
  fsm_line_scheduler_if bus ();
  fsm_line_scheduler #(.CNT_W(8), .PRIO_INIT(1'b0)) dut (
    .clock(clock), .reset(reset), .req(bus), .fsm_reset(fsm_reset),
    .line1(line1), .line2(line2), .overflw(overflw), .ovf_clear(ovf_clear),
    .ovf_count0(ovf_count0), .ovf_count1(ovf_count1)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clock);
    #2;
  endtask
  task automatic frame(input logic ovf, input logic clr);
    tick;
    tick;
    overflw = ovf;
    ovf_clear = clr;
    tick;
    overflw = 1'b0;
    ovf_clear = 1'b0;
    tick;
  endtask
  initial begin
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_line = 2'b10;
    bus.req1_line = 2'b01;
    #1;
    chk("rst_fsm_reset", 32'(fsm_reset), 32'd1);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_readys", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    chk("rst_lines_bubble_done", 32'({line1, line2, bus.bubble, bus.frame_done}), 32'd0);
    chk("rst_counts", 32'({ovf_count0, ovf_count1}), 32'd0);
    bus.req0_valid = 1'b1;
    tick;
    reset = 1'b1;
    #1;
    chk("init_fsm_reset_held", 32'(fsm_reset), 32'd1);
    for (int b = 0; b < 4; b++) begin
      tick;
      #1;
      chk("f0_fsm_reset", 32'(fsm_reset), 32'd0);
      chk("f0_grant", 32'(bus.grant), 32'd1);
      chk("f0_ready0", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
      chk("f0_lines", 32'({line1, line2, bus.bubble}), 32'b100);
      chk("f0_done", 32'(bus.frame_done), 32'(b == 3));
    end
    bus.req1_valid = 1'b1;
    for (int f = 0; f < 4; f++)
      for (int b = 0; b < 4; b++) begin
        tick;
        #1;
        chk("rr_grant", 32'(bus.grant), (f % 2 == 0) ? 32'd1 : 32'd2);
        chk("rr_done", 32'(bus.frame_done), 32'(b == 3));
      end
    bus.req0_valid = 1'b0;
    tick;
    tick;
    tick;
    bus.req1_valid = 1'b0;
    #1;
    chk("bub_grant", 32'(bus.grant), 32'd2);
    chk("bub_ready1", 32'(bus.req1_ready), 32'd1);
    chk("bub_lines", 32'({line1, line2, bus.bubble}), 32'b001);
    chk("bub_not_done", 32'(bus.frame_done), 32'd0);
    bus.req0_valid = 1'b1;
    tick;
    #1;
    chk("bub_end_done", 32'(bus.frame_done), 32'd1);
    chk("bub_end_grant", 32'(bus.grant), 32'd2);
    tick;
    #1;
    chk("ovf_frame_grant", 32'(bus.grant), 32'd1);
    tick;
    tick;
    tick;
    bus.req0_line = 2'b11;
    #1;
    chk("ovf_last_sym", 32'({line1, line2, bus.bubble}), 32'b110);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    tick;
    #1;
    chk("ovf_next_grant", 32'(bus.grant), 32'd2);
    tick;
    overflw = 1'b1;
    tick;
    #1;
    chk("ovf_count0_inc", 32'(ovf_count0), OVF ? 32'd1 : 32'd0);
    chk("ovf_count1_hold", 32'(ovf_count1), 32'd0);
    tick;
    overflw = 1'b0;
    #1;
    chk("ovf_other_beat", 32'(ovf_count0), OVF ? 32'd1 : 32'd0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b0;
    frame(1'b1, 1'b0);
    #1;
    chk("ovf_count1_inc", 32'(ovf_count1), OVF ? 32'd1 : 32'd0);
    chk("ovf_count0_keep", 32'(ovf_count0), OVF ? 32'd1 : 32'd0);
    for (int i = 0; i < 254; i++) frame(1'b1, 1'b0);
    #1;
    chk("sat_reach", 32'(ovf_count0), OVF ? 32'd255 : 32'd0);
    frame(1'b1, 1'b0);
    #1;
    chk("sat_hold", 32'(ovf_count0), OVF ? 32'd255 : 32'd0);
    frame(1'b1, 1'b1);
    #1;
    chk("clear_wins", 32'(ovf_count0), 32'd0);
    chk("clear_count1", 32'(ovf_count1), 32'd0);
    frame(1'b1, 1'b0);
    #1;
    chk("count_after_clear", 32'(ovf_count0), OVF ? 32'd1 : 32'd0);
    tick;
    tick;
    tick;
    #1;
    chk("pre_abort_grant", 32'(bus.grant), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_grant", 32'(bus.grant), 32'd0);
    chk("abort_readys", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    chk("abort_fsm_reset", 32'(fsm_reset), 32'd1);
    chk("abort_lines", 32'({line1, line2, bus.bubble}), 32'd0);
    chk("abort_count0", 32'(ovf_count0), 32'd0);
    tick;
    reset = 1'b1;
    #1;
    chk("rel_fsm_reset", 32'(fsm_reset), 32'd1);
    for (int b = 0; b < 4; b++) begin
      tick;
      #1;
      chk("rel_fsm_reset_low", 32'(fsm_reset), 32'd0);
      chk("rel_grant", 32'(bus.grant), 32'd1);
      chk("rel_done", 32'(bus.frame_done), 32'(b == 3));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
